// File: rtl/mvu_pkg.sv
// Shared MVU definitions: datapath widths and the job-sequencer state encoding.
package mvu_pkg;

  localparam int BCNTDWN = 29;
  localparam int BPREC   = 6;
  localparam int BOCNT   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SEND,
    ST_DRAIN,
    ST_DONE
  } mvu_job_state_t;

  // A precision of zero bit-planes is meaningless, so the hardware treats it as one.
  function automatic logic [BPREC-1:0] eff_prec(input logic [BPREC-1:0] p);
    return (p == '0) ? BPREC'(1) : p;
  endfunction

endpackage

// File: rtl/mvu_job_ctrl.sv
// Per-MVU job sequencer: turns a start strobe plus latched precision config into
// the AGU/accumulator/max-pool/quantizer control strobes for one MVU.
module mvu_job_ctrl
  import mvu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [BCNTDWN-1:0] countdown,
  input  logic [BPREC-1:0]   wprecision,
  input  logic [BPREC-1:0]   iprecision,
  input  logic [BPREC-1:0]   oprecision,
  output logic               inagu_clr,
  output logic               acc_clr,
  output logic               max_clr,
  output logic               quant_clr,
  output logic               quant_start,
  output logic               run_en,
  output logic               busy,
  output logic               done,
  output logic [BOCNT-1:0]   out_count
);

  mvu_job_state_t         state, state_next;
  logic [BCNTDWN-1:0]     remaining;
  logic [2*BPREC-1:0]     group_cnt;
  logic [2*BPREC-1:0]     group_size;
  logic [2*BPREC-1:0]     group_inc;
  logic [BPREC-1:0]       drain_cnt;
  logic [BPREC-1:0]       drain_len;
  logic                   kill;

  assign kill      = abort && (state != ST_IDLE);
  assign group_inc = group_cnt + (2*BPREC)'(1);

  // NOTE: state and counters are flops, so they are written with <= only; blocking
  // assignments here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output and state_next gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    inagu_clr   = 1'b0;
    acc_clr     = 1'b0;
    max_clr     = 1'b0;
    quant_clr   = 1'b0;
    quant_start = 1'b0;
    run_en      = 1'b0;
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        inagu_clr  = 1'b1;
        acc_clr    = 1'b1;
        max_clr    = 1'b1;
        quant_clr  = 1'b1;
        state_next = (remaining != '0) ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        run_en = 1'b1;
        if (group_inc == group_size || remaining == BCNTDWN'(1)) state_next = ST_SEND;
      end
      ST_SEND: begin
        // Quantizer samples the accumulator now; the clear lands at the edge.
        quant_start = 1'b1;
        acc_clr     = 1'b1;
        state_next  = (remaining != '0) ? ST_RUN : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt == BPREC'(1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // abort wins over every transition, including a start in the same cycle.
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining  <= '0;
      group_cnt  <= '0;
      group_size <= (2*BPREC)'(1);
      drain_cnt  <= '0;
      drain_len  <= BPREC'(1);
      out_count  <= '0;
    end else if (!kill) begin
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            remaining  <= countdown;
            group_size <= (2*BPREC)'(eff_prec(wprecision)) * (2*BPREC)'(eff_prec(iprecision));
            drain_len  <= eff_prec(oprecision);
          end
        end
        ST_CLEAR: begin
          out_count <= '0;
          group_cnt <= '0;
          drain_cnt <= drain_len;
        end
        ST_RUN: begin
          remaining <= remaining - BCNTDWN'(1);
          group_cnt <= group_inc;
        end
        ST_SEND: begin
          out_count <= out_count + BOCNT'(1);
          group_cnt <= '0;
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt - BPREC'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
